mio_bus: RTL



---
 rtl/mio_bus.sv | 79 +++++++
 1 files changed

// File: rtl/mio_bus.sv
// mio_bus: CPU memory/IO responder decoding word accesses to block RAM, switches, LEDs and a free-running counter
module mio_bus #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Cpu_data2bus,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);
  localparam int WW = $clog2(RAM_LAT + 1);
  typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [RAM_AW-1:0] a_q;
  logic [31:0] d_q, cnt, wa;
  logic [WW-1:0] wcnt;
  logic req, acc, wr, rd, is_ram, is_sw, is_led, is_cnt, unmapped, wait_end;
  logic unused_ok;
  assign unused_ok = ^addr_bus[1:0];
  assign wa = {addr_bus[31:2], 2'b00};
  assign req = mem_r | mem_w;
  assign acc = (state == IDLE) & req;
  assign wr = mem_w;
  assign rd = mem_r & ~mem_w;
  assign is_ram = addr_bus[31:RAM_AW+2] == '0;
  assign is_sw = wa == 32'hE000_0000;
  assign is_led = wa == 32'hF000_0000;
  assign is_cnt = wa == 32'hF000_0004;
  assign unmapped = ~(is_ram | is_sw | is_led | is_cnt);
  assign wait_end = (state == RAM_WAIT) & (wcnt == WW'(1));
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE     ? (req ? ((rd & is_ram) ? RAM_WAIT : DONE) : IDLE) :
               state == RAM_WAIT ? (wait_end ? DONE : RAM_WAIT) : IDLE;
  end
  always_comb begin
    MIO_ready = (state == DONE) | ((state == IDLE) & ~req);
    ram_addr = a_q;
    ram_din = d_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      d_q <= '0;
      wcnt <= '0;
      data2CPU <= '0;
      led <= '0;
      cnt <= '0;
      bus_err <= 1'b0;
      ram_we <= 1'b0;
    end else begin
      ram_we <= acc & wr & is_ram;
      cnt <= (acc & wr & is_cnt) ? Cpu_data2bus : cnt + 32'd1;
      if (acc) begin
        a_q <= addr_bus[RAM_AW+1:2];
        d_q <= Cpu_data2bus;
        wcnt <= WW'(RAM_LAT);
      end else if (state == RAM_WAIT) wcnt <= wcnt - WW'(1);
      if (acc & wr & is_led) led <= Cpu_data2bus[15:0];
      if (acc & (unmapped | (mem_r & mem_w))) bus_err <= 1'b1;
      if (acc & rd & ~is_ram)
        data2CPU <= is_sw ? {16'h0, sw} : is_led ? {16'h0, led} : is_cnt ? cnt : 32'h0;
      else if (wait_end) data2CPU <= ram_dout;
    end
  end
endmodule
